// File: rtl/mmio_responder_if.sv
// CPU load/store bus between the minisys-32 core and the MMIO responder.
interface mmio_responder_if;
  logic [31:0] Address;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] WriteData;
  logic        io_sel;
  logic        mem_we;
  logic [31:0] io_rdata;
  logic        io_rvalid;

  modport master (
    output Address, MemRead, MemWrite, WriteData,
    input  io_sel, mem_we, io_rdata, io_rvalid
  );

  modport slave (
    input  Address, MemRead, MemWrite, WriteData,
    output io_sel, mem_we, io_rdata, io_rvalid
  );
endinterface

// File: rtl/mmio_responder.sv
// MMIO responder: decodes the I/O window, LED latch, debounced switches, change flag.
// Optional free-running timer at offset 0x080 when MMIO_TIMER_EN is defined.
module mmio_responder #(
  parameter logic [31:0]      IO_BASE         = 32'hFFFF_FC00,
  parameter int unsigned      CNT_W           = 20,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
  input  logic              clock,
  input  logic              reset,
  mmio_responder_if.slave   bus,
  input  logic [7:0]        switch,
  output logic [7:0]        led
);

  localparam logic [7:0] OFF_LED   = 8'h18;  // 0x060
  localparam logic [7:0] OFF_SW    = 8'h1C;  // 0x070
  localparam logic [7:0] OFF_SWCHG = 8'h1D;  // 0x074
  localparam logic [7:0] OFF_TIMER = 8'h20;  // 0x080

  logic [7:0]       led_q, led_d;
  logic [31:0]      io_rdata_q, io_rdata_d;
  logic             io_rvalid_q, io_rvalid_d;
  logic [7:0]       sw_meta_q, sw_meta_d;
  logic [7:0]       sw_s_q, sw_s_d;
  logic [7:0]       sw_db_q, sw_db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             chg_q, chg_d;
`ifdef MMIO_TIMER_EN
  logic [31:0]      timer_q, timer_d;
`endif

  logic       io_sel;
  logic       wr_io;
  logic       rd_io;
  logic [7:0] word;
  logic [31:0] rd_mux;
  logic       deb_done;
  logic       unused_bits;

  assign io_sel      = (bus.Address[31:10] == IO_BASE[31:10]);
  assign wr_io       = bus.MemWrite & io_sel;
  assign rd_io       = bus.MemRead & io_sel;
  assign word        = bus.Address[9:2];
  assign unused_bits = ^{bus.Address[1:0], bus.WriteData[31:8]};

  assign bus.io_sel    = io_sel;
  assign bus.mem_we    = bus.MemWrite & ~io_sel;
  assign bus.io_rdata  = io_rdata_q;
  assign bus.io_rvalid = io_rvalid_q;
  assign led           = led_q;

  always_comb begin
    rd_mux      = '0;
    led_d       = led_q;
    sw_meta_d   = switch;
    sw_s_d      = sw_meta_q;
    sw_db_d     = sw_db_q;
    cnt_d       = cnt_q;
    chg_d       = chg_q;
    deb_done    = 1'b0;
    io_rvalid_d = rd_io;
    io_rdata_d  = io_rdata_q;
`ifdef MMIO_TIMER_EN
    timer_d     = timer_q + 32'd1;
`endif

    // Read mux sees pre-edge state, so a combined read+write returns the old value.
    case (word)
      OFF_LED:   rd_mux = {24'b0, led_q};
      OFF_SW:    rd_mux = {24'b0, sw_db_q};
      OFF_SWCHG: rd_mux = {31'b0, chg_q};
`ifdef MMIO_TIMER_EN
      OFF_TIMER: rd_mux = timer_q;
`endif
      default:   rd_mux = '0;
    endcase
    if (rd_io) io_rdata_d = rd_mux;

    if (wr_io && word == OFF_LED) led_d = bus.WriteData[7:0];
`ifdef MMIO_TIMER_EN
    if (wr_io && word == OFF_TIMER) timer_d = bus.WriteData;
`endif

    if (sw_s_q == sw_db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1'b1)) begin
      sw_db_d  = sw_s_q;
      cnt_d    = '0;
      deb_done = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Set has priority over a simultaneous W1C so no switch event is lost.
    if (wr_io && word == OFF_SWCHG && bus.WriteData[0]) chg_d = 1'b0;
    if (deb_done) chg_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      led_q       <= '0;
      io_rdata_q  <= '0;
      io_rvalid_q <= 1'b0;
      sw_meta_q   <= '0;
      sw_s_q      <= '0;
      sw_db_q     <= '0;
      cnt_q       <= '0;
      chg_q       <= 1'b0;
`ifdef MMIO_TIMER_EN
      timer_q     <= '0;
`endif
    end else begin
      led_q       <= led_d;
      io_rdata_q  <= io_rdata_d;
      io_rvalid_q <= io_rvalid_d;
      sw_meta_q   <= sw_meta_d;
      sw_s_q      <= sw_s_d;
      sw_db_q     <= sw_db_d;
      cnt_q       <= cnt_d;
      chg_q       <= chg_d;
`ifdef MMIO_TIMER_EN
      timer_q     <= timer_d;
`endif
    end
  end

endmodule
